compression_dispatch_scheduler: RTL and testbench

//  Sequences uncompressed stream elements (USEs) onto NUM_COMPRESSION_ELEMENTS compression engines.

---
 rtl/compression_dispatch_scheduler_pkg.sv | 26 ++
 rtl/compression_dispatch_scheduler_if.sv | 40 ++++
 rtl/compression_dispatch_scheduler_dispatch_order_fifo.sv | 70 +++++++
 rtl/compression_dispatch_scheduler.sv | 136 +++++++++++++
 tb/tb_compression_dispatch_scheduler.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/compression_dispatch_scheduler_pkg.sv
// Shared types and helpers for the compression dispatch scheduler.
//   se_idx_t / ce_idx_t : USE and engine index types for the default
//                         configuration (4 USEs, 2 engines)
//   cse_can_accept      : engine ingest rule (idle, or shifting below limit)
//   DISPATCH_CNT_W      : width of the wrapping dispatch counter
package compression_dispatch_scheduler_pkg;

  localparam int DISPATCH_CNT_W = 16;

  localparam int DEF_NSE = 4;
  localparam int DEF_NCE = 2;
  localparam int DEF_SEW = (DEF_NSE > 1) ? $clog2(DEF_NSE) : 1;
  localparam int DEF_CEW = (DEF_NCE > 1) ? $clog2(DEF_NCE) : 1;

  typedef logic [DEF_SEW-1:0] se_idx_t;
  typedef logic [DEF_CEW-1:0] ce_idx_t;

  // An engine takes a new block when it is empty, or when it is draining
  // (shifting) and its remaining output is below the ingest limit.
  function automatic logic cse_can_accept(input logic [15:0] count,
                                          input logic        shift,
                                          input logic [15:0] limit);
    return (count == 16'd0) || ((count < limit) && shift);
  endfunction

endpackage

// File: rtl/compression_dispatch_scheduler_if.sv
// Bus between the USE ring / compression engines / return path and the
// dispatch scheduler.
//   master : the environment (USEs, engines, return drain)
//   slave  : the scheduler
interface compression_dispatch_scheduler_if #(
  parameter int NSE = 4,
  parameter int NCE = 2,
  parameter int CCW = 9
);
  localparam int SEW = (NSE > 1) ? $clog2(NSE) : 1;
  localparam int CEW = (NCE > 1) ? $clog2(NCE) : 1;

  logic [NSE-1:0][7:0]     use_byte_count_in;
  logic [NSE-1:0]          use_data_taken_out;
  logic [NCE-1:0][CCW-1:0] cse_byte_count_in;
  logic [NCE-1:0]          cse_shift_in;
  logic [NCE-1:0][SEW-1:0] engine_sel_out;
  logic [NCE-1:0]          engine_load_out;
  logic [CEW-1:0]          return_engine_out;
  logic                    return_valid_out;
  logic                    return_done_in;
  logic                    order_full_out;
  logic                    underflow_err_out;
  logic [15:0]             dispatch_count_out;

  modport master (
    output use_byte_count_in, cse_byte_count_in, cse_shift_in, return_done_in,
    input  use_data_taken_out, engine_sel_out, engine_load_out,
           return_engine_out, return_valid_out, order_full_out,
           underflow_err_out, dispatch_count_out
  );

  modport slave (
    input  use_byte_count_in, cse_byte_count_in, cse_shift_in, return_done_in,
    output use_data_taken_out, engine_sel_out, engine_load_out,
           return_engine_out, return_valid_out, order_full_out,
           underflow_err_out, dispatch_count_out
  );

endinterface

// File: rtl/compression_dispatch_scheduler_dispatch_order_fifo.sv
// In-order tag FIFO of engine ids, one entry per dispatched block.
//   clk, reset : clock, synchronous active-high reset
//   push       : store pushData (ignored when full)
//   pushData   : engine id of the block just dispatched
//   pop        : current head block fully drained (ignored when empty)
//   head       : engine id at the head (0 when empty)
//   full/empty : occupancy flags
//   underflow  : sticky, set by a pop on an empty FIFO until reset
module compression_dispatch_scheduler_dispatch_order_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          doPush;
  logic          doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      // A pop on an empty FIFO is dropped; a simultaneous push still lands.
      if (pop && empty) begin
        underflow <= 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/compression_dispatch_scheduler.sv
// Dispatches uncompressed stream elements (USEs) onto compression engines,
// both served strictly round-robin, and records the engine order so the
// return path can drain engine output in original stream order.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : slave side of compression_dispatch_scheduler_if
//           (USE counts/taken pulses, engine counts/shift, engine select/load,
//            return head/valid/done, full, underflow, dispatch count)
module compression_dispatch_scheduler
  import compression_dispatch_scheduler_pkg::*;
#(
  parameter int NUM_STREAM_ELEMENTS      = 4,
  parameter int NUM_COMPRESSION_ELEMENTS = 2,
  parameter int FIFO_MAX_INGEST_BYTES    = 16,
  parameter int CSE_COUNT_WIDTH          = 9,
  parameter int ORDER_FIFO_DEPTH         = 8
) (
  input logic clk,
  input logic reset,
  compression_dispatch_scheduler_if.slave bus
);

  localparam int NSE = NUM_STREAM_ELEMENTS;
  localparam int NCE = NUM_COMPRESSION_ELEMENTS;
  localparam int CCW = CSE_COUNT_WIDTH;
  localparam int SEW = (NSE > 1) ? $clog2(NSE) : 1;
  localparam int CEW = (NCE > 1) ? $clog2(NCE) : 1;

  logic [SEW-1:0]            sePtr;
  logic [CEW-1:0]            cePtr;
  logic [NCE-1:0]            holdoff;
  logic [NSE-1:0]            takenQ;
  logic [NCE-1:0]            loadQ;
  logic [NCE-1:0][SEW-1:0]   selQ;
  logic [DISPATCH_CNT_W-1:0] dispatchCnt;

  logic [NSE-1:0] seHit;
  logic [NCE-1:0] ceHit;
  logic [CCW-1:0] selCount;
  logic           selShift;
  logic           selHoldoff;
  logic           useReady;
  logic           engineAccept;
  logic           dispatch;

  logic [CEW-1:0] headEngine;
  logic           orderFull;
  logic           orderEmpty;
  logic           underflow;

  // Pointer decode is done by compare rather than indexing so single-engine
  // builds (1-bit pointer into a 1-entry vector) stay width-clean.
  always_comb begin
    seHit      = '0;
    ceHit      = '0;
    selCount   = '0;
    selShift   = 1'b0;
    selHoldoff = 1'b0;
    useReady   = 1'b0;
    for (int i = 0; i < NSE; i++) begin
      if (sePtr == SEW'(i)) begin
        seHit[i] = 1'b1;
        useReady = (bus.use_byte_count_in[i] != 8'd0);
      end
    end
    for (int e = 0; e < NCE; e++) begin
      if (cePtr == CEW'(e)) begin
        ceHit[e]   = 1'b1;
        selCount   = bus.cse_byte_count_in[e];
        selShift   = bus.cse_shift_in[e];
        selHoldoff = holdoff[e];
      end
    end
    engineAccept = !selHoldoff &&
                   cse_can_accept(16'(selCount), selShift, 16'(FIFO_MAX_INGEST_BYTES));
    // A full FIFO blocks dispatch even when a pop lands this cycle, so the
    // decision never depends on the return path in the same cycle.
    dispatch = useReady && engineAccept && !orderFull;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sePtr       <= '0;
      cePtr       <= '0;
      holdoff     <= '0;
      takenQ      <= '0;
      loadQ       <= '0;
      selQ        <= '0;
      dispatchCnt <= '0;
    end else begin
      takenQ  <= '0;
      loadQ   <= '0;
      // Holdoff lasts one cycle: the engine's byte count lags the load, so
      // a just-loaded engine would otherwise still look idle.
      holdoff <= '0;
      if (dispatch) begin
        takenQ <= seHit;
        loadQ  <= ceHit;
        for (int e = 0; e < NCE; e++) begin
          if (ceHit[e]) begin
            holdoff[e] <= 1'b1;
            selQ[e]    <= sePtr;
          end
        end
        sePtr       <= (sePtr == SEW'(NSE - 1)) ? '0 : sePtr + SEW'(1);
        cePtr       <= (cePtr == CEW'(NCE - 1)) ? '0 : cePtr + CEW'(1);
        dispatchCnt <= dispatchCnt + DISPATCH_CNT_W'(1);
      end
    end
  end

  compression_dispatch_scheduler_dispatch_order_fifo #(
    .DEPTH (ORDER_FIFO_DEPTH),
    .W     (CEW)
  ) u_order_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (dispatch),
    .pushData  (cePtr),
    .pop       (bus.return_done_in),
    .head      (headEngine),
    .full      (orderFull),
    .empty     (orderEmpty),
    .underflow (underflow)
  );

  assign bus.use_data_taken_out = takenQ;
  assign bus.engine_load_out    = loadQ;
  assign bus.engine_sel_out     = selQ;
  assign bus.return_engine_out  = headEngine;
  assign bus.return_valid_out   = !orderEmpty;
  assign bus.order_full_out     = orderFull;
  assign bus.underflow_err_out  = underflow;
  assign bus.dispatch_count_out = dispatchCnt;

endmodule

// File: tb/tb_compression_dispatch_scheduler.sv
module tb_compression_dispatch_scheduler;

  localparam int NSE   = 4;
  localparam int NCE   = 2;
  localparam int DEPTH = 8;
  localparam int LIMIT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic reset1;
  bit   refill;
  int   total = 0;
  int   bad   = 0;

  compression_dispatch_scheduler_if #(.NSE(NSE), .NCE(NCE), .CCW(9)) bus ();
  compression_dispatch_scheduler_if #(.NSE(NSE), .NCE(1),   .CCW(9)) bus1 ();

  compression_dispatch_scheduler #(
    .NUM_STREAM_ELEMENTS(NSE), .NUM_COMPRESSION_ELEMENTS(NCE),
    .FIFO_MAX_INGEST_BYTES(LIMIT), .CSE_COUNT_WIDTH(9), .ORDER_FIFO_DEPTH(DEPTH)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  compression_dispatch_scheduler #(
    .NUM_STREAM_ELEMENTS(NSE), .NUM_COMPRESSION_ELEMENTS(1),
    .FIFO_MAX_INGEST_BYTES(LIMIT), .CSE_COUNT_WIDTH(9), .ORDER_FIFO_DEPTH(DEPTH)
  ) dut1 (.clk(clk), .reset(reset1), .bus(bus1));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model of the main instance: pointers as plain integers,
  // the tag FIFO as a queue, holdoff as "engine dispatched last cycle".
  int   mSe, mCe, mLast, mCnt;
  int   mQ[$];
  bit   mUnder, mValid = 0;
  logic [NSE-1:0] eTaken;
  logic [NCE-1:0] eLoad;
  int   eSel[NCE];

  always @(posedge clk) begin
    int cnt;
    bit sh, acc, disp, full;
    if (reset) begin
      mSe = 0; mCe = 0; mLast = -1; mCnt = 0; mUnder = 0;
      mQ.delete();
      eTaken = '0; eLoad = '0;
      for (int e = 0; e < NCE; e++) eSel[e] = 0;
    end else begin
      full = (mQ.size() == DEPTH);
      cnt  = int'(bus.cse_byte_count_in[mCe]);
      sh   = bus.cse_shift_in[mCe];
      acc  = (mLast != mCe) && (cnt == 0 || (cnt < LIMIT && sh));
      disp = (bus.use_byte_count_in[mSe] != 0) && acc && !full;
      if (bus.return_done_in) begin
        if (mQ.size() == 0) mUnder = 1;
        else void'(mQ.pop_front());
      end
      eTaken = '0; eLoad = '0; mLast = -1;
      if (disp) begin
        eTaken[mSe] = 1'b1;
        eLoad[mCe]  = 1'b1;
        eSel[mCe]   = mSe;
        mQ.push_back(mCe);
        mLast = mCe;
        mSe   = (mSe + 1) % NSE;
        mCe   = (mCe + 1) % NCE;
        mCnt  = (mCnt + 1) % 65536;
      end
    end
    mValid = 1;
  end

  always @(negedge clk) begin
    if (mValid) begin
      check("taken", bus.use_data_taken_out, eTaken);
      check("load", bus.engine_load_out, eLoad);
      for (int e = 0; e < NCE; e++) check("sel", bus.engine_sel_out[e], eSel[e]);
      check("valid", bus.return_valid_out, mQ.size() != 0);
      if (mQ.size() != 0) check("head", bus.return_engine_out, mQ[0]);
      check("full", bus.order_full_out, mQ.size() == DEPTH);
      check("underflow", bus.underflow_err_out, mUnder);
      check("count", bus.dispatch_count_out, mCnt);
    end
  end

  // One clock; USEs whose data was taken clear (or refill) themselves.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NSE; i++)
      if (bus.use_data_taken_out[i]) bus.use_byte_count_in[i] = refill ? 8'd20 : 8'd0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic setAllUse(input logic [7:0] v);
    for (int i = 0; i < NSE; i++) bus.use_byte_count_in[i] = v;
  endtask

  task automatic drain(input int n);
    bus.return_done_in = 1'b1;
    for (int k = 0; k < n; k++) step();
    bus.return_done_in = 1'b0;
  endtask

  initial begin
    int n;
    int guard;
    reset = 1'b1; reset1 = 1'b1; refill = 0;
    bus.use_byte_count_in = '0; bus.cse_byte_count_in = '0;
    bus.cse_shift_in = '0; bus.return_done_in = 1'b0;
    bus1.use_byte_count_in = '0; bus1.cse_byte_count_in = '0;
    bus1.cse_shift_in = '0; bus1.return_done_in = 1'b0;
    step(); step();

    check("rst_taken", bus.use_data_taken_out, 0);
    check("rst_load", bus.engine_load_out, 0);
    check("rst_valid", bus.return_valid_out, 0);
    check("rst_engine", bus.return_engine_out, 0);
    check("rst_count", bus.dispatch_count_out, 0);
    check("rst_full", bus.order_full_out, 0);
    check("rst_underflow", bus.underflow_err_out, 0);

    // 1: four full USEs, idle engines
    setAllUse(8'd20);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_taken", bus.use_data_taken_out, 1 << k);
      check("t1_load", bus.engine_load_out, 1 << (k % 2));
    end
    check("t1_count", bus.dispatch_count_out, 4);
    bus.return_done_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t1_tag", bus.return_engine_out, k % 2);
      step();
    end
    bus.return_done_in = 1'b0;
    check("t1_drained", bus.return_valid_out, 0);

    // 2: empty USE1 stalls the ring
    bus.use_byte_count_in = {8'd0, 8'd20, 8'd0, 8'd20};
    step();
    check("t2_use0", bus.use_data_taken_out, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_stall", bus.use_data_taken_out, 0);
    end
    bus.use_byte_count_in[1] = 8'd20;
    step();
    check("t2_use1", bus.use_data_taken_out, 4'b0010);
    step();
    check("t2_use2", bus.use_data_taken_out, 4'b0100);
    step();
    drain(3);
    check("t2_drained", bus.return_valid_out, 0);

    // 3: E1 busy at/above ingest limit
    setAllUse(8'd20);
    bus.cse_byte_count_in[1] = 9'd16;
    doReset();
    step();
    check("t3_e0", bus.engine_load_out, 2'b01);
    step();
    check("t3_busy16", bus.use_data_taken_out, 0);
    bus.cse_shift_in[1] = 1'b1;
    step();
    check("t3_16shift", bus.use_data_taken_out, 0);
    bus.cse_byte_count_in[1] = 9'd15; bus.cse_shift_in[1] = 1'b0;
    step();
    check("t3_15noshift", bus.use_data_taken_out, 0);
    bus.cse_shift_in[1] = 1'b1;
    step();
    check("t3_e1_taken", bus.use_data_taken_out, 4'b0010);
    check("t3_e1_load", bus.engine_load_out, 2'b10);
    setAllUse(8'd0);
    bus.cse_byte_count_in = '0; bus.cse_shift_in = '0;
    step();
    drain(2);

    // 4: fill the tag FIFO, then release one entry
    refill = 1;
    setAllUse(8'd20);
    doReset();
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.use_data_taken_out != 0) n++;
    end
    check("t4_disp8", n, 8);
    check("t4_full", bus.order_full_out, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_blocked", bus.use_data_taken_out, 0);
    end
    bus.return_done_in = 1'b1;
    step();
    bus.return_done_in = 1'b0;
    check("t4_pop_nodisp", bus.use_data_taken_out, 0);
    check("t4_notfull", bus.order_full_out, 0);
    step();
    check("t4_resume", bus.use_data_taken_out != 0, 1);
    check("t4_count", bus.dispatch_count_out, 9);
    refill = 0;

    // 5: underflow is sticky; reset clears and rewinds pointers
    setAllUse(8'd0);
    doReset();
    bus.return_done_in = 1'b1;
    step();
    bus.return_done_in = 1'b0;
    check("t5_underflow", bus.underflow_err_out, 1);
    bus.use_byte_count_in[0] = 8'd20;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_sticky", bus.underflow_err_out, 1);
    end
    doReset();
    check("t5_clear", bus.underflow_err_out, 0);
    check("t5_count0", bus.dispatch_count_out, 0);
    check("t5_valid0", bus.return_valid_out, 0);
    bus.use_byte_count_in[0] = 8'd20;
    step();
    check("t5_use0", bus.use_data_taken_out, 4'b0001);
    check("t5_e0", bus.engine_load_out, 2'b01);
    drain(1);

    // 6a: single engine, continuous input -> every other cycle
    for (int i = 0; i < NSE; i++) bus1.use_byte_count_in[i] = 8'd20;
    reset1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("nce1_taken", bus1.use_data_taken_out, (k % 2 == 1) ? (1 << ((k - 1) / 2)) : 0);
      check("nce1_load", bus1.engine_load_out, k % 2);
    end
    check("nce1_count", bus1.dispatch_count_out, 4);
    check("nce1_full", bus1.order_full_out, 0);

    // Randomized traffic against the model
    doReset();
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < NSE; i++)
        bus.use_byte_count_in[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      for (int e = 0; e < NCE; e++) begin
        bus.cse_byte_count_in[e] = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(10, 20));
        bus.cse_shift_in[e] = 1'($urandom_range(0, 1));
      end
      bus.return_done_in = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    // 6b: dispatch counter wraps
    refill = 1;
    setAllUse(8'd20);
    bus.cse_byte_count_in = '0; bus.cse_shift_in = '0; bus.return_done_in = 1'b0;
    doReset();
    step();
    bus.return_done_in = 1'b1;
    guard = 0;
    while (bus.dispatch_count_out != 16'hFFFF && guard < 70000) begin
      step();
      guard++;
    end
    check("wrap_reach", bus.dispatch_count_out, 16'hFFFF);
    step();
    check("wrap_zero", bus.dispatch_count_out, 0);
    bus.return_done_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
